// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte handshake between uart_rx and its consumer.
//   rx_data   : received byte, stable while rx_valid=1
//   rx_valid  : holding register full
//   rx_ready  : consumer accepts the byte when rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while holding register full
//   busy      : receiver state machine not idle
// master = receiver side, slave = consumer side.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 115200 baud, 16x oversampling from a
// phase-accumulator tick in the clock50 domain, 3-sample majority vote
// per bit, single-entry holding register with valid/ready handshake.
//   clock50 : 50 MHz system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   rx      : serial line, idle high, asynchronous to clock50
//   bus     : uart_rx_if.master (rx_data, rx_valid, rx_ready,
//             frame_err, overrun, busy)
module uart_rx #(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned ACC_INC   = 2416,
    parameter int unsigned OVS       = 16
) (
    input  logic      clock50,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int unsigned AW1 = ACC_WIDTH + 1;
    localparam int unsigned TW  = $clog2(OVS);
    localparam logic [TW-1:0] T7 = TW'(7);
    localparam logic [TW-1:0] T8 = TW'(8);
    localparam logic [TW-1:0] T9 = TW'(9);
    localparam logic [TW-1:0] TL = TW'(OVS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // baud tick: carry out of the phase accumulator
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 tick;

    assign acc_sum = {1'b0, acc} + AW1'(ACC_INC);
    assign tick    = acc_sum[ACC_WIDTH];

    always_ff @(posedge clock50 or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= acc_sum[ACC_WIDTH-1:0];
    end

    logic rx_m, rx_s;

    always_ff @(posedge clock50 or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0]    bitidx, bitidx_n;
    logic [7:0]    shreg, shreg_n;
    logic          s7, s7_n, s8, s8_n;
    logic          armed, armed_n;
    logic          commit, commit_n;
    logic          stop_ok, stop_ok_n;
    logic          vote;

    // majority of samples at ticks 7, 8 and the live sample at tick 9
    assign vote = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    always_ff @(posedge clock50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tcnt    <= '0;
            bitidx  <= '0;
            shreg   <= '0;
            s7      <= 1'b1;
            s8      <= 1'b1;
            armed   <= 1'b1;
            commit  <= 1'b0;
            stop_ok <= 1'b0;
        end else begin
            state   <= state_n;
            tcnt    <= tcnt_n;
            bitidx  <= bitidx_n;
            shreg   <= shreg_n;
            s7      <= s7_n;
            s8      <= s8_n;
            armed   <= armed_n;
            commit  <= commit_n;
            stop_ok <= stop_ok_n;
        end
    end

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        bitidx_n  = bitidx;
        shreg_n   = shreg;
        s7_n      = s7;
        s8_n      = s8;
        // a low stop bit disarms start detection until the line is seen high
        armed_n   = armed | rx_s;
        commit_n  = 1'b0;
        stop_ok_n = stop_ok;

        if (state != IDLE && tick) begin
            tcnt_n = tcnt + 1'b1;
            if (tcnt == T7) s7_n = rx_s;
            if (tcnt == T8) s8_n = rx_s;
        end

        unique case (state)
            IDLE: begin
                if (!rx_s && armed) begin
                    state_n = START;
                    tcnt_n  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt == T9 && vote) state_n = IDLE;
                    if (tcnt == TL) begin
                        state_n  = DATA;
                        tcnt_n   = '0;
                        bitidx_n = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == T9) shreg_n = {vote, shreg[7:1]};
                    if (tcnt == TL) begin
                        tcnt_n = '0;
                        if (bitidx == 3'd7) state_n  = STOP;
                        else                bitidx_n = bitidx + 3'd1;
                    end
                end
            end
            STOP: begin
                // commit at the stop-bit vote so back-to-back frames are caught
                if (tick && tcnt == T9) begin
                    state_n   = IDLE;
                    commit_n  = 1'b1;
                    stop_ok_n = vote;
                    if (!vote) armed_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // holding register state after this cycle's accept
    logic valid_keep;
    assign valid_keep = bus.rx_valid & ~bus.rx_ready;

    always_ff @(posedge clock50 or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.rx_valid  <= valid_keep;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
            if (commit) begin
                if (!stop_ok) begin
                    bus.frame_err <= 1'b1;
                end else if (!valid_keep) begin
                    bus.rx_data  <= shreg;
                    bus.rx_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    logic clock50 = 1'b0;
    logic rst_n;
    logic rx;

    uart_rx_if bus ();

    uart_rx #(.ACC_WIDTH(16), .ACC_INC(2416), .OVS(16)) dut (
        .clock50 (clock50),
        .rst_n   (rst_n),
        .rx      (rx),
        .bus     (bus)
    );

    always #10 clock50 = ~clock50;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: frames whose outcome is pending ({stop_ok, data}), holding register
    logic [8:0] exp_q[$];
    int         accepted[$];
    logic       model_full = 1'b0;
    logic [7:0] model_data = '0;
    logic       ready_prev = 1'b0;
    logic [7:0] prev_data  = '0;
    int         ferr_seen  = 0;
    int         ovr_seen   = 0;

    always @(negedge clock50) begin
        logic [8:0] e;
        logic       ev;
        if (!rst_n) begin
            chk("rst_rx_data",   bus.rx_data,   0);
            chk("rst_rx_valid",  bus.rx_valid,  0);
            chk("rst_frame_err", bus.frame_err, 0);
            chk("rst_overrun",   bus.overrun,   0);
            chk("rst_busy",      bus.busy,      0);
            model_full = 1'b0;
            exp_q.delete();
            ready_prev = 1'b0;
        end else begin
            if (model_full && ready_prev) begin
                accepted.push_back(int'(prev_data));
                model_full = 1'b0;
            end
            ev = bus.frame_err || bus.overrun || (bus.rx_valid && !model_full);
            if (ev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {bus.frame_err, bus.overrun, bus.rx_valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[8] && model_full) begin
                        chk("ovr_pulse",  bus.overrun,   1);
                        chk("ovr_ferr",   bus.frame_err, 0);
                        chk("ovr_valid",  bus.rx_valid,  1);
                        chk("ovr_data",   bus.rx_data,   model_data);
                    end else if (e[8]) begin
                        chk("load_valid", bus.rx_valid,  1);
                        chk("load_data",  bus.rx_data,   e[7:0]);
                        chk("load_ovr",   bus.overrun,   0);
                        chk("load_ferr",  bus.frame_err, 0);
                        model_full = 1'b1;
                        model_data = e[7:0];
                    end else begin
                        chk("ferr_pulse", bus.frame_err, 1);
                        chk("ferr_ovr",   bus.overrun,   0);
                        chk("ferr_valid", bus.rx_valid,  model_full);
                    end
                end
            end else begin
                chk("valid_track", bus.rx_valid, model_full);
                if (model_full) chk("data_stable", bus.rx_data, model_data);
            end
            ferr_seen += int'(bus.frame_err);
            ovr_seen  += int'(bus.overrun);
            ready_prev = bus.rx_ready;
            prev_data  = bus.rx_data;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clock50);
        #1;
    endtask

    // rst_bit >= 0 pulses reset in the middle of that data bit; no outcome expected
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int bt,
                              input int rst_bit);
        rx = 1'b0;
        clks(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == rst_bit) begin
                clks(bt / 2);
                rst_n = 1'b0;
                clks(20);
                rst_n = 1'b1;
                clks(bt - bt / 2 - 20);
            end else begin
                clks(bt);
            end
        end
        rx = stop_v;
        if (rst_bit < 0) exp_q.push_back({stop_v, d});
        clks(bt);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) clks(1);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic test_single(input logic [7:0] d, input int bt);
        int idx;
        idx = accepted.size();
        bus.rx_ready = 1'b0;
        send_frame(d, 1'b1, bt, -1);
        for (int i = 0; i < 2000 && !bus.rx_valid; i++) clks(1);
        chk("single_valid", bus.rx_valid, 1);
        chk("single_data", bus.rx_data, d);
        clks(10);
        chk("single_hold", bus.rx_valid, 1);
        bus.rx_ready = 1'b1;
        clks(1);
        bus.rx_ready = 1'b0;
        clks(3);
        chk("single_drop", bus.rx_valid, 0);
        chk("single_acc_cnt", accepted.size() - idx, 1);
        chk("single_acc_data", (accepted.size() > idx) ? accepted[idx] : -1, d);
        clks(200);
    endtask

    initial begin
        #(80000 * 20);
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst_n = 1'b0;
        rx = 1'b1;
        bus.rx_ready = 1'b0;
        clks(5);
        rst_n = 1'b1;
        clks(100);
        chk("idle_busy", bus.busy, 0);

        test_single(8'h40, 434);

        // back-to-back with consumer always ready
        idx = accepted.size();
        bus.rx_ready = 1'b1;
        send_frame(8'h55, 1'b1, 434, -1);
        send_frame(8'hAA, 1'b1, 434, -1);
        wait_drain("b2b_drain");
        clks(5);
        bus.rx_ready = 1'b0;
        chk("b2b_first",  (accepted.size() > idx)     ? accepted[idx]     : -1, 8'h55);
        chk("b2b_second", (accepted.size() > idx + 1) ? accepted[idx + 1] : -1, 8'hAA);
        chk("b2b_no_err", ferr_seen + ovr_seen, 0);

        // glitch shorter than the vote window
        rx = 1'b0;
        clks(20);
        chk("glitch_busy", bus.busy, 1);
        clks(80);
        rx = 1'b1;
        clks(434);
        chk("glitch_idle", bus.busy, 0);
        chk("glitch_valid", bus.rx_valid, 0);

        // low stop bit followed by a break
        send_frame(8'h3C, 1'b0, 434, -1);
        clks(868);
        chk("break_idle", bus.busy, 0);
        chk("ferr_count", ferr_seen, 1);
        chk("ferr_valid", bus.rx_valid, 0);
        rx = 1'b1;
        clks(434);
        test_single(8'h12, 434);

        // overrun with consumer stalled
        idx = accepted.size();
        bus.rx_ready = 1'b0;
        send_frame(8'h01, 1'b1, 434, -1);
        send_frame(8'h02, 1'b1, 434, -1);
        wait_drain("ovr_drain");
        clks(2);
        chk("ovr_count", ovr_seen, 1);
        chk("ovr_keep_data", bus.rx_data, 8'h01);
        chk("ovr_keep_valid", bus.rx_valid, 1);
        bus.rx_ready = 1'b1;
        clks(1);
        bus.rx_ready = 1'b0;
        clks(3);
        chk("ovr_acc_data", (accepted.size() > idx) ? accepted[idx] : -1, 8'h01);
        chk("ovr_drop", bus.rx_valid, 0);

        // reset mid-bit 4 of a frame whose remaining bits are high
        send_frame(8'hF0, 1'b1, 434, 4);
        clks(434);
        chk("rst_idle", bus.busy, 0);
        chk("rst_no_byte", bus.rx_valid, 0);
        test_single(8'h7E, 434);

        // baud tolerance
        test_single(8'h40, 425);
        test_single(8'h40, 443);

        wait_drain("final_drain");
        chk("final_ferr", ferr_seen, 1);
        chk("final_ovr", ovr_seen, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
